// File: rtl/phase_seq_pkg.sv
// phase_seq_pkg: phase vector width and one-hot bit indices shared by the sequencer and phase-gated blocks
package phase_seq_pkg;
  localparam int phase_h = 4;
  localparam int ph_f = 0;
  localparam int ph_d = 1;
  localparam int ph_e = 2;
  localparam int ph_m = 3;
  localparam int ph_w = 4;
endpackage

// File: rtl/wait_timer.sv
// wait_timer: loadable wait-cycle counter; expired when the count reaches TIMEOUT_CYC (TIMEOUT_CYC=0 never expires)
// ports: clk, rst (async high), load (restart at 1 next cycle), expired (current wait cycle is the last allowed)
module wait_timer #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic load,
  output logic expired
);
  localparam int W = $clog2(TIMEOUT_CYC + 1) + 1;
  logic [W-1:0] cnt_q, cnt_d;
  always_comb cnt_d = load ? W'(1) : cnt_q + W'(1);
  always_ff @(posedge clk or posedge rst)
    if (rst) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign expired = (TIMEOUT_CYC != 0) && (cnt_q == W'(TIMEOUT_CYC));
endmodule

// File: rtl/phase_seq.sv
// phase_seq: multi-cycle CPU phase sequencer with memory handshakes, run/step/halt control and bus-timeout fault
// ports: clk, rst (async high), run, step, halt_req, need_mem, imem_ack, dmem_ack in;
//        phase (one-hot f/d/e/m/w), imem_req, dmem_req, busy, halted, fault, instr_cnt out (all registered)
module phase_seq
  import phase_seq_pkg::*;
#(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             run,
  input  logic             step,
  input  logic             halt_req,
  input  logic             need_mem,
  input  logic             imem_ack,
  input  logic             dmem_ack,
  output logic [phase_h:0] phase,
  output logic             imem_req,
  output logic             dmem_req,
  output logic             busy,
  output logic             halted,
  output logic             fault,
  output logic [31:0]      instr_cnt
);
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_FAULT} state_t;
  state_t state_q, state_d;
  logic mem_pend_q, mem_pend_d, step_mode_q, step_mode_d, halt_lat_q, halt_lat_d;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic [phase_h:0] phase_q, phase_d;
  logic imem_req_q, imem_req_d, dmem_req_q, dmem_req_d;
  logic busy_q, busy_d, halted_q, halted_d, fault_q, fault_d;
  logic tmr_load, expired;
  wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .load   (tmr_load),
    .expired(expired)
  );
  always_comb begin
    state_d = state_q;
    mem_pend_d = mem_pend_q;
    step_mode_d = step_mode_q;
    halt_lat_d = halt_lat_q | (halt_req & (state_q != S_IDLE));
    case (state_q)
      S_IDLE: begin
        state_d = (step || run) ? S_FETCH : S_IDLE;
        step_mode_d = step;
      end
      S_FETCH: state_d = imem_ack ? S_DECODE : expired ? S_FAULT : S_FETCH;
      S_DECODE: state_d = S_EXEC;
      S_EXEC: begin
        state_d = S_MEM;
        mem_pend_d = need_mem;
      end
      S_MEM: state_d = (!mem_pend_q || dmem_ack) ? S_WB : expired ? S_FAULT : S_MEM;
      S_WB: state_d = (halt_lat_d || step_mode_q || !run) ? S_IDLE : S_FETCH;
      default: state_d = S_FAULT;
    endcase
    if (state_d == S_IDLE) begin
      halt_lat_d = 1'b0;
      step_mode_d = 1'b0;
    end
    // WB lasts exactly one cycle, so counting on entry retires each instruction once
    instr_cnt_d = instr_cnt_q + 32'(state_d == S_WB);
    tmr_load = (state_d != state_q) && (state_d == S_FETCH || (state_d == S_MEM && mem_pend_d));
    phase_d = '0;
    phase_d[ph_f] = state_d == S_FETCH;
    phase_d[ph_d] = state_d == S_DECODE;
    phase_d[ph_e] = state_d == S_EXEC;
    phase_d[ph_m] = state_d == S_MEM;
    phase_d[ph_w] = state_d == S_WB;
    imem_req_d = state_d == S_FETCH;
    dmem_req_d = state_d == S_MEM && mem_pend_d;
    busy_d = |phase_d;
    halted_d = state_d == S_IDLE;
    fault_d = state_d == S_FAULT;
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      mem_pend_q <= 1'b0;
      step_mode_q <= 1'b0;
      halt_lat_q <= 1'b0;
      instr_cnt_q <= '0;
      phase_q <= '0;
      imem_req_q <= 1'b0;
      dmem_req_q <= 1'b0;
      busy_q <= 1'b0;
      halted_q <= 1'b1;
      fault_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mem_pend_q <= mem_pend_d;
      step_mode_q <= step_mode_d;
      halt_lat_q <= halt_lat_d;
      instr_cnt_q <= instr_cnt_d;
      phase_q <= phase_d;
      imem_req_q <= imem_req_d;
      dmem_req_q <= dmem_req_d;
      busy_q <= busy_d;
      halted_q <= halted_d;
      fault_q <= fault_d;
    end
  end
  assign phase = phase_q;
  assign imem_req = imem_req_q;
  assign dmem_req = dmem_req_q;
  assign busy = busy_q;
  assign halted = halted_q;
  assign fault = fault_q;
  assign instr_cnt = instr_cnt_q;
endmodule

// File: tb/tb_phase_seq.sv
// tb_phase_seq: table-driven and directed checks of the phase sequencer
module tb_phase_seq;
  logic clk = 0, rst = 1;
  logic run = 0, step = 0, halt_req = 0, need_mem = 0, imem_ack = 0, dmem_ack = 0;
  logic [4:0] phase;
  logic imem_req, dmem_req, busy, halted, fault;
  logic [31:0] instr_cnt;
  int tests = 0, fails = 0;

  always #5 clk = ~clk;

  phase_seq #(.TIMEOUT_CYC(4)) dut (
    .clk(clk), .rst(rst), .run(run), .step(step), .halt_req(halt_req),
    .need_mem(need_mem), .imem_ack(imem_ack), .dmem_ack(dmem_ack),
    .phase(phase), .imem_req(imem_req), .dmem_req(dmem_req), .busy(busy),
    .halted(halted), .fault(fault), .instr_cnt(instr_cnt)
  );

  typedef struct {
    logic run, step, halt, nm, ia, da;
    logic [4:0] ph;
    logic ireq, dreq, hlt, flt;
    logic [31:0] cnt;
  } vec_t;
  vec_t v[$];

  task automatic add(input logic r, s, h, nm, ia, da, input logic [4:0] ph,
                     input logic dreq, flt, input logic [31:0] cnt);
    vec_t x;
    x.run = r; x.step = s; x.halt = h; x.nm = nm; x.ia = ia; x.da = da;
    x.ph = ph; x.ireq = (ph == 5'd1); x.dreq = dreq; x.flt = flt;
    x.hlt = (ph == 5'd0) && !flt; x.cnt = cnt;
    v.push_back(x);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [4:0] ph, input logic ir, dr, b, h, f,
                         input logic [31:0] c);
    chk({name, ".phase"}, 32'(phase), 32'(ph));
    chk({name, ".imem_req"}, 32'(imem_req), 32'(ir));
    chk({name, ".dmem_req"}, 32'(dmem_req), 32'(dr));
    chk({name, ".busy"}, 32'(busy), 32'(b));
    chk({name, ".halted"}, 32'(halted), 32'(h));
    chk({name, ".fault"}, 32'(fault), 32'(f));
    chk({name, ".instr_cnt"}, instr_cnt, c);
  endtask

  task automatic drive(input logic r, s, h, nm, ia, da);
    run = r; step = s; halt_req = h; need_mem = nm; imem_ack = ia; dmem_ack = da;
  endtask

  initial begin
    int wcnt;
    bit done;
    // run with zero-wait acks: 1,2,4,8,16 repeating, then run drops at WB
    for (int i = 0; i < 15; i++) add(1, 0, 0, 0, 1, 1, 5'(1 << (i % 5)), 0, 0, 32'((i + 1) / 5));
    add(0, 0, 0, 0, 1, 1, 0, 0, 0, 3);
    // imem ack on 4th FETCH cycle (timeout boundary), need_mem, dmem ack on 3rd MEM cycle
    add(1, 0, 0, 0, 0, 0, 1, 0, 0, 3);
    for (int i = 0; i < 3; i++) add(0, 0, 0, 0, 0, 0, 1, 0, 0, 3);
    add(0, 0, 0, 0, 1, 0, 2, 0, 0, 3);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0, 3);
    add(0, 0, 0, 1, 0, 1, 8, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 8, 1, 0, 3);
    add(0, 0, 0, 0, 0, 0, 8, 1, 0, 3);
    add(0, 0, 0, 0, 0, 1, 16, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 4);
    // single step with run low
    add(0, 1, 0, 0, 0, 0, 1, 0, 0, 4);
    add(0, 0, 0, 0, 1, 0, 2, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 4, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 8, 0, 0, 4);
    add(0, 0, 0, 0, 0, 0, 16, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 5);
    // step and run together: still one instruction
    add(1, 1, 0, 0, 0, 0, 1, 0, 0, 5);
    add(1, 0, 0, 0, 1, 0, 2, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 8, 0, 0, 5);
    add(1, 0, 0, 0, 0, 0, 16, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 6);
    // halt pulse in DECODE
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 6);
    add(1, 0, 0, 0, 1, 0, 2, 0, 0, 6);
    add(1, 0, 1, 0, 0, 0, 4, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 8, 0, 0, 6);
    add(1, 0, 0, 0, 0, 0, 16, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 7);
    // halt pulse in the WB cycle
    add(1, 0, 0, 0, 1, 0, 1, 0, 0, 7);
    add(1, 0, 0, 0, 1, 0, 2, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0, 4, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0, 8, 0, 0, 7);
    add(1, 0, 0, 0, 0, 0, 16, 0, 0, 8);
    add(1, 0, 1, 0, 0, 0, 0, 0, 0, 8);
    add(0, 0, 0, 0, 0, 0, 0, 0, 0, 8);
    // no imem ack: FAULT after the 4th FETCH cycle, sticky
    for (int i = 0; i < 4; i++) add(1, 0, 0, 0, 0, 0, 1, 0, 0, 8);
    add(1, 0, 0, 0, 0, 0, 0, 0, 1, 8);
    add(1, 0, 0, 0, 1, 1, 0, 0, 1, 8);
    add(1, 1, 0, 0, 1, 1, 0, 0, 1, 8);

    repeat (2) @(negedge clk);
    chk_all("reset_held", 0, 0, 0, 0, 1, 0, 0);
    rst = 0;
    @(negedge clk);
    chk_all("reset_idle", 0, 0, 0, 0, 1, 0, 0);
    for (int i = 0; i < v.size(); i++) begin
      drive(v[i].run, v[i].step, v[i].halt, v[i].nm, v[i].ia, v[i].da);
      @(negedge clk);
      chk_all($sformatf("vec%0d", i), v[i].ph, v[i].ireq, v[i].dreq, v[i].ph != 0,
              v[i].hlt, v[i].flt, v[i].cnt);
    end

    // asynchronous reset out of FAULT
    drive(0, 0, 0, 0, 0, 0);
    #2 rst = 1;
    #1 chk_all("fault_rst", 0, 0, 0, 0, 1, 0, 0);
    @(negedge clk) rst = 0;

    // reset mid MEM wait, asynchronously
    drive(1, 0, 0, 1, 1, 0);
    repeat (4) @(negedge clk);
    chk_all("mem_wait", 8, 0, 1, 1, 0, 0, 0);
    #2 rst = 1;
    #1 chk_all("mem_rst", 0, 0, 0, 0, 1, 0, 0);
    drive(0, 0, 0, 0, 0, 0);
    @(negedge clk) rst = 0;
    wcnt = 0;
    repeat (3) begin
      @(negedge clk);
      if (phase[4]) wcnt++;
    end
    chk("no_w_after_rst", 32'(wcnt), 0);

    // counter wrap
    force dut.instr_cnt_q = 32'hFFFF_FFFF;
    @(negedge clk);
    release dut.instr_cnt_q;
    @(negedge clk);
    chk("cnt_forced", instr_cnt, 32'hFFFF_FFFF);
    drive(0, 1, 0, 0, 1, 1);
    @(negedge clk);
    step = 0;
    wcnt = 0;
    done = 0;
    for (int i = 0; i < 20 && !done; i++) begin
      @(negedge clk);
      if (phase[4]) wcnt++;
      done = halted;
    end
    chk("wrap_done", 32'(done), 1);
    chk("wrap_w_pulses", 32'(wcnt), 1);
    chk("wrap_cnt", instr_cnt, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
